// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM states, Booth select codes and iteration sizing for seq_booth_multiplier
package mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_sel_t;
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a radix-4 multiplier window {b[2i+1],b[2i],b[2i-1]} to a partial-product select
module booth_r4_encoder
  import mul_pkg::*;
(
  input  logic [2:0] window,
  output booth_sel_t sel
);
  always_comb
    sel = (window == 3'b000 || window == 3'b111) ? ZERO :
          window == 3'b011 ? POS2 :
          window == 3'b100 ? NEG2 :
          window[2] ? NEG1 : POS1;
endmodule

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: multi-cycle radix-4 Booth multiplier, start/done/busy handshake, optional SEQ_MUL_ZERO_SKIP_EN zero bypass
module seq_booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int ITER = iter_count(WIDTH);
  localparam int HW = WIDTH + 4;
  localparam int LW = WIDTH + 2;
  localparam int CW = $clog2(ITER + 1);
  state_t state, state_nx;
  booth_sel_t sel;
  logic [HW-1:0] hi, sum, addend, a1, a2;
  logic [LW-1:0] lo, a_ext;
  logic [CW-1:0] cnt;
  logic prev, zero_op;
  booth_r4_encoder u_enc (.window({lo[1:0], prev}), .sel(sel));
`ifdef SEQ_MUL_ZERO_SKIP_EN
  assign zero_op = op_a == '0 || op_b == '0;
`else
  assign zero_op = 1'b0;
`endif
  assign a1 = {{2{a_ext[LW-1]}}, a_ext};
  assign a2 = {a_ext[LW-1], a_ext, 1'b0};
  assign addend = sel == POS1 ? a1 : sel == POS2 ? a2 : sel == NEG1 ? -a1 : sel == NEG2 ? -a2 : '0;
  assign sum = hi + addend;
  assign busy = state == CALC;
  assign done = state == FIN;
  always_comb
    state_nx = state == IDLE ? (start ? (zero_op ? FIN : CALC) : IDLE) :
               state == CALC ? (cnt == '0 ? FIN : CALC) : IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      a_ext   <= '0;
      prev    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_ext <= {{2{signed_mode & op_a[WIDTH-1]}}, op_a};
        lo    <= {{2{signed_mode & op_b[WIDTH-1]}}, op_b};
        hi    <= '0;
        prev  <= 1'b0;
        cnt   <= CW'(ITER);
        if (zero_op) product <= '0;
      end else if (state == CALC && cnt != '0) begin
        {hi, lo} <= {{2{sum[HW-1]}}, sum, lo[LW-1:2]};
        prev     <= lo[1];
        cnt      <= cnt - 1'b1;
      end else if (state == CALC) begin
        product <= {hi[WIDTH-3:0], lo};
      end
    end
  end
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed self-checking bench for 16-bit and 8-bit multiplier instances
module tb_seq_booth_multiplier;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, sm = 1'b0, start8 = 1'b0, sm8 = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy, done, busy8, done8;
  logic [31:0] product;
  logic [15:0] product8;
  int errors = 0, checks = 0;
`ifdef SEQ_MUL_ZERO_SKIP_EN
  localparam int ZLAT16 = 0, ZLAT8 = 0;
`else
  localparam int ZLAT16 = 10, ZLAT8 = 6;
`endif
  always #5 clk = ~clk;
  seq_booth_multiplier #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .op_a(a), .op_b(b),
    .busy(busy), .done(done), .product(product)
  );
  seq_booth_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .op_a(a8), .op_b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input bit w8, input bit s, input logic [15:0] x, input logic [15:0] y,
                     input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    @(posedge clk);
    @(negedge clk);
    if (w8) begin start8 = 1'b1; sm8 = s; a8 = x[7:0]; b8 = y[7:0]; end
    else begin start = 1'b1; sm = s; a = x; b = y; end
    @(posedge clk);
    #1;
    start = 1'b0; start8 = 1'b0;
    a = ~x; b = ~y; a8 = ~x[7:0]; b8 = ~y[7:0]; sm = ~s; sm8 = ~s;
    chk({tag, " busy_after_accept"}, w8 ? busy8 : busy, exp_lat != 0);
    lat = 0;
    while (!(w8 ? done8 : done) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " product"}, w8 ? {16'h0, product8} : product, exp);
    chk({tag, " busy_in_done"}, w8 ? busy8 : busy, 1'b0);
  endtask
  initial begin
    int lat, seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset product", product, 32'h0);
    rst_n = 1'b1;
    run(0, 1, 16'h0002, 16'h0003, 32'h00000006, 10, "s 2*3");
    run(0, 1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD, 10, "s -1*3");
    run(0, 0, 16'hFFFF, 16'h0003, 32'h0002FFFD, 10, "u FFFF*3");
    run(0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 10, "u FFFF*FFFF");
    run(0, 1, 16'hFFF6, 16'hFFF1, 32'h00000096, 10, "s -10*-15");
    run(0, 1, 16'h8000, 16'h8000, 32'h40000000, 10, "s 8000*8000");
    run(0, 1, 16'h8000, 16'h7FFF, 32'hC0008000, 10, "s 8000*7FFF");
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; sm = 1'b1; a = 16'h029D; b = 16'h03E4;
    @(posedge clk);
    #1;
    a = 16'hFF61; b = 16'h0058;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b first latency", lat, 10);
    chk("b2b first product", product, 32'h000A2AD4);
    @(posedge clk);
    #1;
    chk("b2b done-cycle start ignored", busy, 1'b0);
    chk("b2b single done pulse", done, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b second accept", busy, 1'b1);
    start = 1'b0; a = 16'h1234; b = 16'h4321; sm = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b second latency", lat, 10);
    chk("b2b second product", product, 32'hFFFFC958);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; sm = 1'b1; a = 16'h1234; b = 16'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst product", product, 32'h0);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (done) seen++; end
    chk("midrst no done", seen, 0);
    run(0, 1, 16'h0000, 16'h006F, 32'h00000000, ZLAT16, "zero16");
    run(1, 1, 16'h0080, 16'h0080, 32'h00004000, 6, "w8 80*80");
    run(1, 1, 16'h0000, 16'h006F, 32'h00000000, ZLAT8, "w8 zero");
    run(1, 0, 16'h00FF, 16'h00FF, 32'h0000FE01, 6, "w8 u FF*FF");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
